// File: rtl/hex8_arb_pkg.sv
// hex8 memory arbiter shared types.
// State, owner encodings and default lock bound.
package hex8_arb_pkg;

  typedef enum logic [1:0] {
    ARB    = 2'd0,
    LOCKED = 2'd1,
    YIELD  = 2'd2
  } state_t;

  typedef enum logic {
    CORE = 1'b0,
    HOST = 1'b1
  } owner_t;

  localparam int LOCK_MAX_DEF = 16;

endpackage

// File: rtl/hex8_lock_timer.sv
// Host lock duration counter.
// Flags expiry when the count reaches LOCK_MAX-1.
module hex8_lock_timer
  import hex8_arb_pkg::*;
#(
  parameter int LOCK_MAX = LOCK_MAX_DEF
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(LOCK_MAX + 1);

  logic [CW-1:0] cnt;

  // clear has priority over counting
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expired = (cnt == CW'(LOCK_MAX - 1));

endmodule

// File: rtl/hex8_mem_arbiter.sv
// Round-robin core/host arbiter for the hex8 memory.
// Host may lock for bursts; lock is bounded by a core slot.
module hex8_mem_arbiter
  import hex8_arb_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int LOCK_MAX = LOCK_MAX_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              c_req_valid,
  output logic              c_req_ready,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_rsp_valid,
  output logic [DATA_W-1:0] c_rdata,
  output logic              c_stall,
  input  logic              h_req_valid,
  output logic              h_req_ready,
  input  logic              h_we,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [DATA_W-1:0] h_wdata,
  output logic              h_rsp_valid,
  output logic [DATA_W-1:0] h_rdata,
  input  logic              h_lock,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              lock_active,
  output logic [7:0]        core_wait
);

  state_t state;
  owner_t last_grant;
  owner_t rsp_owner;
  logic   rsp_pend;
  logic   c_win;
  logic   c_xfer;
  logic   h_xfer;
  logic   tmr_clear;
  logic   tmr_en;
  logic   expired;

  // grant decision; nothing is ready while reset is held
  always_comb begin
    c_win       = 1'b0;
    c_req_ready = 1'b0;
    h_req_ready = 1'b0;
    if (resetn) begin
      unique case (state)
        ARB: begin
          c_win = c_req_valid &
                  (~h_req_valid | (last_grant == HOST));
          c_req_ready = c_win;
          h_req_ready = h_req_valid & ~c_win;
        end
        LOCKED: h_req_ready = h_req_valid;
        YIELD:  c_req_ready = c_req_valid;
        default: ;
      endcase
    end
  end

  assign c_xfer = c_req_valid & c_req_ready;
  assign h_xfer = h_req_valid & h_req_ready;
  assign c_stall = c_req_valid & ~c_req_ready;

  // memory port mux, zero when idle
  always_comb begin
    mem_en    = c_xfer | h_xfer;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (1'b1)
      c_xfer: begin
        mem_we    = c_we;
        mem_addr  = c_addr;
        mem_wdata = c_wdata;
      end
      h_xfer: begin
        mem_we    = h_we;
        mem_addr  = h_addr;
        mem_wdata = h_wdata;
      end
      default: ;
    endcase
  end

  // lock timer starts at 1 on the locking transfer
  always_comb begin
    tmr_clear = ((state == LOCKED) & ~h_lock) |
                (state == YIELD);
    tmr_en    = ((state == ARB) & h_xfer & h_lock) |
                (state == LOCKED);
  end

  hex8_lock_timer #(
    .LOCK_MAX(LOCK_MAX)
  ) u_timer (
    .clk    (clk),
    .resetn (resetn),
    .clear  (tmr_clear),
    .enable (tmr_en),
    .expired(expired)
  );

  // arbitration FSM, round-robin history and read tag
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= ARB;
      last_grant <= HOST;
      rsp_pend   <= 1'b0;
      rsp_owner  <= CORE;
    end else begin
      if (mem_en) begin
        last_grant <= h_xfer ? HOST : CORE;
        rsp_owner  <= h_xfer ? HOST : CORE;
      end
      rsp_pend <= mem_en & ~mem_we;
      unique case (state)
        ARB: begin
          if (h_xfer & h_lock) state <= LOCKED;
        end
        LOCKED: begin
          if (!h_lock)      state <= ARB;
          else if (expired) state <= YIELD;
        end
        YIELD:   state <= ARB;
        default: state <= ARB;
      endcase
    end
  end

  // saturating count of core stall cycles
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      core_wait <= 8'h00;
    end else if (c_stall && core_wait != 8'hFF) begin
      core_wait <= core_wait + 8'h01;
    end
  end

  assign lock_active = (state == LOCKED);
  assign c_rsp_valid = rsp_pend & (rsp_owner == CORE);
  assign h_rsp_valid = rsp_pend & (rsp_owner == HOST);
  assign c_rdata = c_rsp_valid ? mem_rdata : '0;
  assign h_rdata = h_rsp_valid ? mem_rdata : '0;

endmodule

// File: tb/tb_hex8_mem_arbiter.sv
// Bench for hex8_mem_arbiter with LOCK_MAX=4.
// Cycle model for grants, queue scoreboard for reads.
module tb_hex8_mem_arbiter;

  localparam int LM = 4;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       c_req_valid = 1'b0;
  logic       c_req_ready;
  logic       c_we = 1'b0;
  logic [7:0] c_addr = 8'h00;
  logic [7:0] c_wdata = 8'h00;
  logic       c_rsp_valid;
  logic [7:0] c_rdata;
  logic       c_stall;
  logic       h_req_valid = 1'b0;
  logic       h_req_ready;
  logic       h_we = 1'b0;
  logic [7:0] h_addr = 8'h00;
  logic [7:0] h_wdata = 8'h00;
  logic       h_rsp_valid;
  logic [7:0] h_rdata;
  logic       h_lock = 1'b0;
  logic       mem_en;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata = 8'h00;
  logic       lock_active;
  logic [7:0] core_wait;

  always #5 clk = ~clk;

  hex8_mem_arbiter #(
    .ADDR_W(8), .DATA_W(8), .LOCK_MAX(LM)
  ) dut (
    .clk(clk), .resetn(resetn),
    .c_req_valid(c_req_valid), .c_req_ready(c_req_ready),
    .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_rsp_valid(c_rsp_valid), .c_rdata(c_rdata),
    .c_stall(c_stall),
    .h_req_valid(h_req_valid), .h_req_ready(h_req_ready),
    .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_rsp_valid(h_rsp_valid), .h_rdata(h_rdata),
    .h_lock(h_lock),
    .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .lock_active(lock_active), .core_wait(core_wait)
  );

  // synchronous memory macro
  logic [7:0] ram [256];
  logic [7:0] exp_mem [256];

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  typedef struct {
    bit         host;
    logic [7:0] data;
  } rsp_t;

  rsp_t q[$];

  int n_checks = 0;
  int n_errors = 0;

  int m_state;
  bit m_last;
  int m_cnt;
  int m_wait;
  bit e_cr;
  bit e_hr;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_last  = 1'b1;
    m_cnt   = 0;
    m_wait  = 0;
    q.delete();
  endtask

  // apply inputs, then check combinational grant and outputs
  task automatic drive(input bit cv, input bit cw,
                       input logic [7:0] ca, input logic [7:0] cd,
                       input bit hv, input bit hw,
                       input logic [7:0] ha, input logic [7:0] hd,
                       input bit hl);
    logic [7:0] ea;
    logic [7:0] ed;
    bit         ew;
    c_req_valid = cv; c_we = cw; c_addr = ca; c_wdata = cd;
    h_req_valid = hv; h_we = hw; h_addr = ha; h_wdata = hd;
    h_lock = hl;
    #1;
    e_cr = 1'b0;
    e_hr = 1'b0;
    if (m_state == 0) begin
      if (cv && hv) begin
        e_cr = m_last;
        e_hr = !m_last;
      end else begin
        e_cr = cv;
        e_hr = hv;
      end
    end else if (m_state == 1) begin
      e_hr = hv;
    end else begin
      e_cr = cv;
    end
    ea = e_cr ? ca : (e_hr ? ha : 8'h00);
    ed = e_cr ? cd : (e_hr ? hd : 8'h00);
    ew = e_cr ? cw : (e_hr ? hw : 1'b0);
    check("c_req_ready", c_req_ready, e_cr);
    check("h_req_ready", h_req_ready, e_hr);
    check("mem_en", mem_en, e_cr | e_hr);
    check("mem_we", mem_we, ew);
    check("mem_addr", mem_addr, ea);
    check("mem_wdata", mem_wdata, ed);
    check("c_stall", c_stall, cv & !e_cr);
    check("lock_active", lock_active, m_state == 1);
    check("core_wait", core_wait, m_wait);
  endtask

  // advance the model and clock, then score responses
  task automatic commit();
    rsp_t e;
    bit   tc;
    bit   th;
    tc = c_req_valid && e_cr;
    th = h_req_valid && e_hr;
    if (tc && !c_we) q.push_back('{host: 1'b0, data: exp_mem[c_addr]});
    if (th && !h_we) q.push_back('{host: 1'b1, data: exp_mem[h_addr]});
    if (tc && c_we) exp_mem[c_addr] = c_wdata;
    if (th && h_we) exp_mem[h_addr] = h_wdata;
    if (tc || th) m_last = th;
    if (c_req_valid && !e_cr && m_wait < 255) m_wait++;
    case (m_state)
      0: if (th && h_lock) begin m_state = 1; m_cnt = 1; end
      1: begin
        if (!h_lock) begin
          m_state = 0; m_cnt = 0;
        end else if (m_cnt == LM - 1) begin
          m_state = 2; m_cnt = 0;
        end else begin
          m_cnt++;
        end
      end
      default: m_state = 0;
    endcase
    @(posedge clk);
    @(negedge clk);
    if (q.size() > 0) begin
      e = q.pop_front();
      check("c_rsp_valid", c_rsp_valid, !e.host);
      check("h_rsp_valid", h_rsp_valid, e.host);
      if (e.host) check("h_rdata", h_rdata, e.data);
      else        check("c_rdata", c_rdata, e.data);
    end else begin
      check("c_rsp_idle", c_rsp_valid, 1'b0);
      check("h_rsp_idle", h_rsp_valid, 1'b0);
    end
  endtask

  task automatic idle();
    drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0);
    commit();
  endtask

  initial begin
    int run;
    for (int i = 0; i < 256; i++) begin
      ram[i] = 8'(i * 7 + 3);
      exp_mem[i] = 8'(i * 7 + 3);
    end
    ram[5] = 8'hA7;
    exp_mem[5] = 8'hA7;
    model_reset();

    // reset held with both requesting
    resetn = 1'b0;
    c_req_valid = 1'b1;
    h_req_valid = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_c_ready", c_req_ready, 1'b0);
    check("rst_h_ready", h_req_ready, 1'b0);
    check("rst_mem_en", mem_en, 1'b0);
    check("rst_mem_addr", mem_addr, 8'h00);
    check("rst_lock", lock_active, 1'b0);
    check("rst_wait", core_wait, 8'h00);
    check("rst_c_rsp", c_rsp_valid, 1'b0);
    check("rst_h_rsp", h_rsp_valid, 1'b0);
    @(negedge clk);
    resetn = 1'b1;

    // round-robin C,H,C,H
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 8'h10, 8'h00, 1, 0, 8'h20, 8'h00, 0);
      check("rr_core", c_req_ready, (i % 2) == 0);
      commit();
    end
    idle();

    // single core read latency
    drive(1, 0, 8'h05, 8'h00, 0, 0, 8'h00, 8'h00, 0);
    commit();
    check("lat_c_rdata", c_rdata, 8'hA7);
    check("lat_h_rsp", h_rsp_valid, 1'b0);
    idle();

    // core write then host readback
    drive(1, 1, 8'h40, 8'h33, 0, 0, 8'h00, 8'h00, 0);
    commit();
    drive(0, 0, 8'h00, 8'h00, 1, 0, 8'h40, 8'h00, 0);
    commit();
    idle();
    check("wr_h_rdata", exp_mem[8'h40], 8'h33);

    // unlock on the expiry cycle returns to ARB
    drive(0, 0, 8'h00, 8'h00, 1, 0, 8'h01, 8'h00, 1);
    commit();
    drive(1, 0, 8'h02, 8'h00, 1, 0, 8'h03, 8'h00, 1);
    commit();
    drive(1, 0, 8'h02, 8'h00, 1, 0, 8'h04, 8'h00, 1);
    commit();
    drive(1, 0, 8'h02, 8'h00, 1, 0, 8'h05, 8'h00, 0);
    commit();
    drive(1, 0, 8'h06, 8'h00, 1, 0, 8'h07, 8'h00, 0);
    check("unl_no_lock", lock_active, 1'b0);
    check("unl_core_wins", c_req_ready, 1'b1);
    commit();
    idle();

    // bounded lock with continuous contention
    run = 0;
    for (int i = 0; i < 340; i++) begin
      drive(1, ($urandom_range(0, 3) == 0),
            8'($urandom_range(0, 255)), 8'($urandom),
            1, 0, 8'($urandom_range(0, 255)), 8'h00, 1);
      if (lock_active) begin
        run++;
      end else if (run != 0) begin
        check("lock_run", run, LM - 1);
        run = 0;
      end
      commit();
    end
    check("wait_sat", core_wait, 8'hFF);
    idle();
    idle();

    // reset right after a host read is accepted
    drive(0, 0, 8'h00, 8'h00, 1, 0, 8'h21, 8'h00, 0);
    @(posedge clk);
    #1 resetn = 1'b0;
    #1;
    check("mid_h_rsp", h_rsp_valid, 1'b0);
    check("mid_h_rdata", h_rdata, 8'h00);
    check("mid_c_rsp", c_rsp_valid, 1'b0);
    check("mid_wait", core_wait, 8'h00);
    model_reset();
    h_req_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    idle();
    idle();
    idle();

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
